writeback_port: RTL and testbench
=================================

# writeback_port

Writer-side block for the 32x32 register file write port (write_enable / write_register / in_data). It merges single-cycle ALU results with results from the long-latency multiply/divide unit (MDU) onto the one write port. Merging uses fixed ALU priority and a small MDU result FIFO. It also keeps a pending-destination scoreboard so decode can stall reads of registers whose MDU result has not yet been committed.

## Interface
Parameters:
- DEPTH, 4, MDU result FIFO entries (power of two, ≥2)
- AW, 5, register index width
- DW, 32, data width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  FIFO can accept; transfer when mdu_valid && mdu_ready
- mdu_rd  in  AW  MDU destination register
- mdu_data  in  DW  MDU result
- issue_valid  in  1  MDU op issued by decode this cycle
- issue_rd  in  AW  destination of issued MDU op
- query_rs, query_rt  in  AW  decode source registers
- rs_pending, rt_pending  out  1  source has uncommitted MDU result (combinational from scoreboard)
- write_enable  out  1  to register file
- write_register  out  AW  to register file
- in_data  out  DW  to register file
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy

## Operation
- The output stage is a register: write_enable, write_register, in_data and internal flag from_mdu. It reloads every edge.
- Arbitration at each edge:
  - alu_valid=1: the output loads the ALU result.
  - Otherwise, if the FIFO is non-empty: the head is popped and loaded with from_mdu=1.
  - Otherwise: write_enable loads 0.
- The ALU has strict priority. A continuous ALU stream may starve the FIFO. mdu_ready then throttles the MDU.
- Register 0 is never written:
  - alu_valid with alu_rd=0 drives write_enable=0. The slot is consumed and the FIFO does not pop that cycle.
  - An MDU transfer with mdu_rd=0 is accepted and discarded; it is not stored.
- mdu_ready = (fifo_count < DEPTH). It is computed from registered count only; no credit is given for a same-edge pop.
- FIFO: circular buffer with rd/wr pointers of log2(DEPTH) bits that wrap modulo DEPTH. A push and a pop on the same edge leave the count unchanged.
- Scoreboard: a pending vector of 2^AW bits.
  - Set bit issue_rd on an edge with issue_valid=1 and issue_rd≠0.
  - Clear bit write_register on an edge where the output register holds write_enable=1 && from_mdu=1. This is the edge the register file commits the value, so pending covers the whole in-flight window.
  - Set and clear of the same bit on the same edge: set wins.
  - Bit 0 is always 0.
- Decode contract: no second MDU issue to a register that is already pending. The bench flags a violation as an error. The block's behaviour under a violation is set-wins, with no counting.
- rs_pending = pending[query_rs]; rt_pending = pending[query_rt].

## Timing
- Reset (async assert, sync-safe release):
  - write_enable=0, write_register=0, in_data=0, from_mdu=0.
  - FIFO empty, fifo_count=0, mdu_ready=1, pending all 0, rs/rt_pending=0.
- A reset that arrives mid-operation drops all queued MDU results and all pending bits.
- ALU latency: alu_valid sampled at edge k → write_enable=1 during cycle k..k+1 → register file commits at edge k+1.
- MDU latency, no contention:
  - transfer at edge k → head visible after k → popped at edge k+1 → committed at edge k+2.
  - pending clears at edge k+2.
- No same-edge push-to-pop bypass.
- Full: at fifo_count=DEPTH, mdu_ready=0 and mdu_valid is ignored. mdu_ready rises in the cycle after a pop edge.
- Empty with no ALU: write_enable=0; no pop.
- Query outputs update in the same cycle as edges that change pending; there is no extra delay.

## Test plan
- Reset: assert rst asynchronously mid-cycle with 2 entries queued and pending[5]=1 → all outputs 0 immediately, mdu_ready=1, fifo_count=0.
- ALU path: alu_valid=1, alu_rd=8, alu_data=0x1234 at edge k → write_enable=1, write_register=8, in_data=0x1234 after k; R[8]=0x1234 after k+1. alu_rd=0, data 0xFFFF → write_enable stays 0.
- MDU path with scoreboard: issue_rd=9 at edge 0; query_rs=9 → rs_pending=1. MDU transfer rd=9 data=81 at edge 3 → write at edge 5, R[9]=81, rs_pending=0 after edge 5.
- Priority/starvation: alu_valid=1 for 6 consecutive cycles while the MDU pushes rd=16..19 → FIFO reaches 4, mdu_ready=0, no MDU writes. On ALU idle, rd 16..19 are written in order on 4 consecutive edges.
- Wrap and simultaneous push/pop: stream 10 MDU results (rd 10..19) with no ALU → all written in order, pointers wrap twice, fifo_count never exceeds 2.
- Set-vs-clear: commit rd=12 on the same edge as issue_rd=13, then commit rd=13 on the same edge as issue_rd=12 → pending[13]=1 and pending[12]=0 after the first edge; pending[12]=1 and pending[13]=0 after the second.

Source files
------------

// File: rtl/writeback_port.sv
// writeback_port
//   Writer side of the register file write port. It merges single-cycle ALU
//   results with queued MDU results onto one registered write port. The ALU
//   always has priority. It also tracks which registers still have an MDU
//   result in flight, so decode can stall reads of those registers.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   alu_valid/alu_rd/alu_data     ALU result (no backpressure)
//   mdu_valid/mdu_ready/mdu_rd/mdu_data   MDU result handshake into the FIFO
//   issue_valid/issue_rd          MDU op issued by decode (marks rd pending)
//   query_rs/query_rt             decode source registers
//   rs_pending/rt_pending         source has an uncommitted MDU result
//   write_enable/write_register/in_data   registered register file write port
//   fifo_count                    MDU FIFO occupancy
module writeback_port #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [DW-1:0]            alu_data,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [AW-1:0]            mdu_rd,
    input  logic [DW-1:0]            mdu_data,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_rd,
    input  logic [AW-1:0]            query_rs,
    input  logic [AW-1:0]            query_rt,
    output logic                     rs_pending,
    output logic                     rt_pending,
    output logic                     write_enable,
    output logic [AW-1:0]            write_register,
    output logic [DW-1:0]            in_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PW   = $clog2(DEPTH);
    localparam int NREG = 1 << AW;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    // FIFO storage and pointers
    logic [AW-1:0] mem_rd_q   [DEPTH];
    logic [AW-1:0] mem_rd_d   [DEPTH];
    logic [DW-1:0] mem_data_q [DEPTH];
    logic [DW-1:0] mem_data_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    // Output stage
    logic          write_enable_q, write_enable_d;
    logic [AW-1:0] write_register_q, write_register_d;
    logic [DW-1:0] in_data_q, in_data_d;
    logic          from_mdu_q, from_mdu_d;

    // Scoreboard
    logic [NREG-1:0] pending_q, pending_d;

    logic accept, push, pop;

    // Ready only looks at the registered count. A pop on the same edge does
    // not free a slot early, so the full condition never depends on alu_valid.
    assign mdu_ready = (count_q < FULL_CNT);
    assign accept    = mdu_valid && mdu_ready;
    // A result for r0 completes the handshake but is dropped instead of stored.
    assign push      = accept && (mdu_rd != '0);
    // The FIFO drains only in cycles the ALU leaves free. That includes ALU
    // writes to r0: that slot is still consumed.
    assign pop       = !alu_valid && (count_q != '0);

    always_comb begin
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_rd_d[wr_ptr_q]   = mdu_rd;
            mem_data_d[wr_ptr_q] = mdu_data;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        write_enable_d   = 1'b0;
        write_register_d = write_register_q;
        in_data_d        = in_data_q;
        from_mdu_d       = 1'b0;
        if (alu_valid) begin
            write_enable_d   = (alu_rd != '0);
            write_register_d = alu_rd;
            in_data_d        = alu_data;
        end else if (pop) begin
            write_enable_d   = 1'b1;
            write_register_d = mem_rd_q[rd_ptr_q];
            in_data_d        = mem_data_q[rd_ptr_q];
            from_mdu_d       = 1'b1;
        end
    end

    // Clear on the edge where the register file commits the MDU value. The set
    // is applied after the clear, so a same-edge set wins.
    always_comb begin
        pending_d = pending_q;
        if (write_enable_q && from_mdu_q) begin
            pending_d[write_register_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_rd_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            write_enable_q   <= 1'b0;
            write_register_q <= '0;
            in_data_q        <= '0;
            from_mdu_q       <= 1'b0;
            pending_q        <= '0;
        end else begin
            mem_rd_q         <= mem_rd_d;
            mem_data_q       <= mem_data_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            write_enable_q   <= write_enable_d;
            write_register_q <= write_register_d;
            in_data_q        <= in_data_d;
            from_mdu_q       <= from_mdu_d;
            pending_q        <= pending_d;
        end
    end

    assign write_enable   = write_enable_q;
    assign write_register = write_register_q;
    assign in_data        = in_data_q;
    assign fifo_count     = count_q;
    assign rs_pending     = pending_q[query_rs];
    assign rt_pending     = pending_q[query_rt];

endmodule

// File: tb/tb_writeback_port.sv
// tb_writeback_port
//   Bench for writeback_port. It combines a vector table, hand-written corner
//   sequences and a random phase. All of them are checked every cycle against
//   a queue-based reference model of the write port and the scoreboard.
module tb_writeback_port;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          mdu_valid = 1'b0;
    logic          mdu_ready;
    logic [AW-1:0] mdu_rd = '0;
    logic [DW-1:0] mdu_data = '0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_rd = '0;
    logic [AW-1:0] query_rs = '0;
    logic [AW-1:0] query_rt = '0;
    logic          rs_pending, rt_pending;
    logic          write_enable;
    logic [AW-1:0] write_register;
    logic [DW-1:0] in_data;
    logic [2:0]    fifo_count;

    writeback_port #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .query_rs(query_rs), .query_rt(query_rt),
        .rs_pending(rs_pending), .rt_pending(rt_pending),
        .write_enable(write_enable), .write_register(write_register), .in_data(in_data),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [AW-1:0] rd; logic [DW-1:0] data; } ent_t;
    ent_t          mq[$];
    logic          m_we, m_from;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;
    bit            m_pend[32];

    task automatic model_reset();
        mq.delete();
        m_we = 0; m_from = 0; m_rd = '0; m_data = '0;
        foreach (m_pend[i]) m_pend[i] = 0;
    endtask

    task automatic model_edge();
        bit   room;
        ent_t e;
        room = (mq.size() < DEPTH);
        if (issue_valid && issue_rd != 0 && m_pend[issue_rd])
            chk("decode_contract_reissue", 32'(issue_rd), 32'(0));
        if (m_we && m_from) m_pend[m_rd] = 0;
        if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1;
        if (alu_valid) begin
            m_we = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data; m_from = 0;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_we = 1; m_rd = e.rd; m_data = e.data; m_from = 1;
        end else begin
            m_we = 0; m_from = 0;
        end
        if (mdu_valid && room && mdu_rd != 0) begin
            e.rd = mdu_rd; e.data = mdu_data;
            mq.push_back(e);
        end
    endtask

    task automatic compare_all();
        chk("write_enable", 32'(write_enable), 32'(m_we));
        if (m_we) begin
            chk("write_register", 32'(write_register), 32'(m_rd));
            chk("in_data", in_data, m_data);
        end
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("mdu_ready", 32'(mdu_ready), 32'(mq.size() < DEPTH));
        chk("rs_pending", 32'(rs_pending), 32'(m_pend[query_rs]));
        chk("rt_pending", 32'(rt_pending), 32'(m_pend[query_rt]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_in();
        alu_valid = 0; mdu_valid = 0; issue_valid = 0;
    endtask

    task automatic drain(input int n);
        idle_in();
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic av; logic [4:0] ard; logic [31:0] adata;
        logic mv; logic [4:0] mrd; logic [31:0] mdata;
        logic iv; logic [4:0] ird; logic [4:0] qrs; logic [4:0] qrt;
        logic ewe; logic [4:0] ewr; logic [31:0] edata;
        logic [2:0] ecnt; logic erdy; logic ers; logic ert;
    } vec_t;
    localparam int NV = 14;
    vec_t tbl[NV];

    initial begin : main
        int         wlog[$];
        int         maxc;
        logic [4:0] r;

        tbl[0]  = '{1, 8, 32'h1234, 0, 0, 0,      0, 0,  0, 0,  1, 8, 32'h1234, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 32'hFFFF, 0, 0, 0,      0, 0,  0, 0,  0, 0, 0,        0, 1, 0, 0};
        tbl[2]  = '{0, 0, 0,        0, 0, 0,      1, 9,  9, 0,  0, 0, 0,        0, 1, 1, 0};
        tbl[3]  = '{0, 0, 0,        0, 0, 0,      0, 0,  9, 0,  0, 0, 0,        0, 1, 1, 0};
        tbl[4]  = '{0, 0, 0,        0, 0, 0,      0, 0,  9, 0,  0, 0, 0,        0, 1, 1, 0};
        tbl[5]  = '{0, 0, 0,        1, 9, 81,     0, 0,  9, 0,  0, 0, 0,        1, 1, 1, 0};
        tbl[6]  = '{0, 0, 0,        0, 0, 0,      0, 0,  9, 0,  1, 9, 81,       0, 1, 1, 0};
        tbl[7]  = '{0, 0, 0,        0, 0, 0,      0, 0,  9, 0,  0, 0, 0,        0, 1, 0, 0};
        tbl[8]  = '{0, 0, 0,        1, 0, 32'hDEAD, 0, 0, 0, 0,  0, 0, 0,        0, 1, 0, 0};
        tbl[9]  = '{0, 0, 0,        0, 0, 0,      0, 0,  0, 0,  0, 0, 0,        0, 1, 0, 0};
        tbl[10] = '{0, 0, 0,        0, 0, 0,      1, 13, 0, 13, 0, 0, 0,        0, 1, 0, 1};
        tbl[11] = '{0, 0, 0,        1, 13, 32'h55, 0, 0, 0, 13, 0, 0, 0,        1, 1, 0, 1};
        tbl[12] = '{0, 0, 0,        0, 0, 0,      0, 0,  0, 13, 1, 13, 32'h55,  0, 1, 0, 1};
        tbl[13] = '{0, 0, 0,        0, 0, 0,      0, 0,  0, 13, 0, 0, 0,        0, 1, 0, 0};

        // Reset state
        model_reset();
        #2;
        chk("rst_we", 32'(write_enable), 0);
        chk("rst_wr", 32'(write_register), 0);
        chk("rst_data", in_data, 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ready", 32'(mdu_ready), 1);
        chk("rst_rs", 32'(rs_pending), 0);
        @(negedge clk); rst = 0;

        // Table vectors
        for (int i = 0; i < NV; i++) begin
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adata;
            mdu_valid = tbl[i].mv; mdu_rd = tbl[i].mrd; mdu_data = tbl[i].mdata;
            issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
            query_rs = tbl[i].qrs; query_rt = tbl[i].qrt;
            step();
            chk($sformatf("vec%0d_we", i), 32'(write_enable), 32'(tbl[i].ewe));
            if (tbl[i].ewe) begin
                chk($sformatf("vec%0d_wr", i), 32'(write_register), 32'(tbl[i].ewr));
                chk($sformatf("vec%0d_data", i), in_data, tbl[i].edata);
            end
            chk($sformatf("vec%0d_cnt", i), 32'(fifo_count), 32'(tbl[i].ecnt));
            chk($sformatf("vec%0d_rdy", i), 32'(mdu_ready), 32'(tbl[i].erdy));
            chk($sformatf("vec%0d_rs", i), 32'(rs_pending), 32'(tbl[i].ers));
            chk($sformatf("vec%0d_rt", i), 32'(rt_pending), 32'(tbl[i].ert));
        end
        drain(2);

        // Starvation: ALU busy for 6 cycles while the MDU fills the FIFO
        for (int i = 0; i < 6; i++) begin
            alu_valid = 1; alu_rd = 5'(1 + i); alu_data = 32'hA000 + i;
            mdu_valid = 1; mdu_rd = (i < 4) ? 5'(16 + i) : 5'd20; mdu_data = 32'h100 + i;
            step();
            chk("starve_alu_wr", 32'(write_register), 32'(1 + i));
        end
        chk("starve_count_full", 32'(fifo_count), 4);
        chk("starve_ready_low", 32'(mdu_ready), 0);
        idle_in();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("starve_drain_we", 32'(write_enable), 1);
            chk("starve_drain_wr", 32'(write_register), 32'(16 + i));
            chk("starve_drain_data", in_data, 32'h100 + i);
            if (i == 0) chk("starve_ready_rise", 32'(mdu_ready), 1);
        end
        drain(2);

        // Wrap: 10 back-to-back MDU results, no ALU
        maxc = 0;
        for (int i = 0; i < 20; i++) begin
            alu_valid = 0; issue_valid = 0;
            mdu_valid = (i < 10); mdu_rd = 5'(10 + i); mdu_data = 32'(i * 7);
            step();
            if (write_enable) wlog.push_back(int'(write_register));
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        end
        chk("wrap_max_count_le2", 32'(maxc <= 2), 1);
        chk("wrap_nwrites", 32'(wlog.size()), 10);
        for (int i = 0; i < wlog.size() && i < 10; i++)
            chk("wrap_order", 32'(wlog[i]), 32'(10 + i));
        drain(2);

        // Set-vs-clear on the same edge, two registers
        query_rs = 12; query_rt = 13;
        idle_in(); issue_valid = 1; issue_rd = 12; step();
        idle_in(); mdu_valid = 1; mdu_rd = 12; mdu_data = 32'hC12; step();
        idle_in(); step();
        idle_in(); issue_valid = 1; issue_rd = 13; step();   // commit 12 / set 13
        chk("svc1_pend12", 32'(rs_pending), 0);
        chk("svc1_pend13", 32'(rt_pending), 1);
        idle_in(); mdu_valid = 1; mdu_rd = 13; mdu_data = 32'hC13; step();
        idle_in(); step();
        idle_in(); issue_valid = 1; issue_rd = 12; step();   // commit 13 / set 12
        chk("svc2_pend12", 32'(rs_pending), 1);
        chk("svc2_pend13", 32'(rt_pending), 0);
        idle_in(); mdu_valid = 1; mdu_rd = 12; step();
        drain(3);

        // Async reset mid-cycle with 2 queued entries and pending[5]
        query_rs = 5;
        idle_in(); alu_valid = 1; alu_rd = 1; issue_valid = 1; issue_rd = 5; step();
        idle_in(); alu_valid = 1; alu_rd = 2; mdu_valid = 1; mdu_rd = 21; step();
        idle_in(); alu_valid = 1; alu_rd = 3; mdu_valid = 1; mdu_rd = 22; step();
        chk("pre_rst_count", 32'(fifo_count), 2);
        chk("pre_rst_rs5", 32'(rs_pending), 1);
        idle_in();
        #2 rst = 1;
        #1;
        chk("mid_rst_we", 32'(write_enable), 0);
        chk("mid_rst_wr", 32'(write_register), 0);
        chk("mid_rst_data", in_data, 0);
        chk("mid_rst_count", 32'(fifo_count), 0);
        chk("mid_rst_ready", 32'(mdu_ready), 1);
        chk("mid_rst_rs5", 32'(rs_pending), 0);
        model_reset();
        @(negedge clk); rst = 0;
        drain(2);

        // Random phase against the model
        for (int n = 0; n < 1500; n++) begin
            alu_valid = ($urandom_range(0, 2) == 0);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            mdu_valid = ($urandom_range(0, 1) == 1);
            mdu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mdu_data  = $urandom;
            r = 5'($urandom_range(1, 31));
            issue_valid = ($urandom_range(0, 3) == 0) && !m_pend[r];
            issue_rd    = r;
            query_rs = 5'($urandom_range(0, 31));
            query_rt = 5'($urandom_range(0, 31));
            step();
        end
        drain(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end

endmodule
